// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that shares a bank of DEPTH x WIDTH flops among NREQ requesters.
// Each transaction runs select -> grant (bank access) -> ack, one transaction per three cycles.
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        rdata,
    output logic                    busy,
    output logic [DEPTH*WIDTH-1:0]  q_bank
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    state_t                 state;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          win;
    logic                   op_wr;
    logic [AW-1:0]          op_addr;
    logic [WIDTH-1:0]       op_wdata;
    logic [DEPTH*WIDTH-1:0] bank;

    logic [PW-1:0]          pick;
    logic                   pick_valid;
    logic [WIDTH-1:0]       rd_word;
    logic [PW-1:0]          next_ptr;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Scanning offsets from high to low lets the lowest offset from ptr win.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
                pick       = wrap_add(ptr, k);
                pick_valid = 1'b1;
            end
        end
    end

    // Addresses at or beyond DEPTH match no word, so reads of them return zero.
    always_comb begin
        rd_word = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (op_addr == AW'(j)) rd_word = bank[j*WIDTH +: WIDTH];
        end
    end

    assign next_ptr = wrap_add(win, 1);
    assign q_bank   = bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            op_wr    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            bank     <= '0;
            gnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win      <= pick;
                        op_wr    <= wr[pick];
                        op_addr  <= addr[pick*AW +: AW];
                        op_wdata <= wdata[pick*WIDTH +: WIDTH];
                        gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (op_wr) begin
                        for (int j = 0; j < DEPTH; j++) begin
                            if (op_addr == AW'(j)) bank[j*WIDTH +: WIDTH] <= op_wdata;
                        end
                    end else begin
                        rdata <= rd_word;
                    end
                    gnt   <= '0;
                    ack   <= gnt;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int DEPTH = 3;
    localparam int AW    = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       wr;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*W-1:0]     wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [W-1:0]          rdata;
    logic                  busy;
    logic [DEPTH*W-1:0]    q_bank;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 0;

    logic [NREQ-1:0] last_gnt;
    logic [NREQ-1:0] last_ack;
    logic [W-1:0]    last_rdata;
    int              order_q[$];

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .q_bank(q_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting, 1 = granted, 2 = acknowledging.
    int         m_phase;
    int         m_win;
    int         m_ptr;
    int         m_addr;
    logic       m_wr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic [7:0] m_bank [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_win = 0; m_ptr = 0; m_addr = 0;
            m_wr = 1'b0; m_wdata = '0; m_rdata = '0;
            for (int j = 0; j < DEPTH; j++) m_bank[j] = '0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                end
                m_wr    = wr[m_win];
                m_addr  = int'(addr[m_win*AW +: AW]);
                m_wdata = wdata[m_win*W +: W];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_wr) begin
                if (m_addr < DEPTH) m_bank[m_addr] = m_wdata;
            end else begin
                m_rdata = (m_addr < DEPTH) ? m_bank[m_addr] : 8'h00;
            end
            m_phase = 2;
        end else begin
            m_ptr   = (m_win + 1) % NREQ;
            m_phase = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic [NREQ-1:0]    e_gnt;
            logic [NREQ-1:0]    e_ack;
            logic [DEPTH*W-1:0] e_q;
            e_gnt = (m_phase == 1) ? NREQ'(1 << m_win) : '0;
            e_ack = (m_phase == 2) ? NREQ'(1 << m_win) : '0;
            for (int j = 0; j < DEPTH; j++) e_q[j*W +: W] = m_bank[j];
            checkOutput("gnt", 32'(gnt), 32'(e_gnt));
            checkOutput("ack", 32'(ack), 32'(e_ack));
            checkOutput("busy", 32'(busy), 32'(m_phase != 0));
            checkOutput("q_bank", 32'(q_bank), 32'(e_q));
            if (m_phase == 2 && !m_wr) checkOutput("rdata", 32'(rdata), 32'(m_rdata));
            if (gnt != '0) order_q.push_back($clog2(gnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int who, input logic w, input int a,
                                 input logic [7:0] d, input logic tamper);
        req = '0; wr = '0; addr = '0; wdata = '0;
        req[who] = 1'b1;
        wr[who] = w;
        addr[who*AW +: AW] = AW'(a);
        wdata[who*W +: W] = d;
        tick();
        last_gnt = gnt;
        if (tamper) begin
            wdata[who*W +: W] = 8'hFF;
            addr[who*AW +: AW] = AW'(0);
            req = '0;
        end
        tick();
        last_ack   = ack;
        last_rdata = rdata;
        req = '0;
        tick();
    endtask

    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 3, 1};

    initial begin
        req = '0; wr = '0; addr = '0; wdata = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        started = 1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_q", 32'(q_bank), 32'h0);
        repeat (5) tick();
        checkOutput("idle_q", 32'(q_bank), 32'h0);
        checkOutput("idle_busy", 32'(busy), 32'h0);

        applyStimulus(0, 1'b1, 2, 8'hA5, 1'b0);
        checkOutput("wr0_gnt", 32'(last_gnt), 32'h1);
        checkOutput("wr0_ack", 32'(last_ack), 32'h1);
        checkOutput("wr0_word2", 32'(q_bank[2*W +: W]), 32'hA5);

        applyStimulus(1, 1'b0, 2, 8'h00, 1'b0);
        checkOutput("rd1_ack", 32'(last_ack), 32'h2);
        checkOutput("rd1_rdata", 32'(last_rdata), 32'hA5);

        applyStimulus(2, 1'b1, 1, 8'h3C, 1'b1);
        checkOutput("latch_ack", 32'(last_ack), 32'h4);
        checkOutput("latch_word1", 32'(q_bank[1*W +: W]), 32'h3C);

        applyStimulus(3, 1'b1, 3, 8'h77, 1'b0);
        checkOutput("oob_wr_ack", 32'(last_ack), 32'h8);
        checkOutput("oob_wr_q", 32'(q_bank), 32'hA53C00);

        applyStimulus(3, 1'b0, 3, 8'h00, 1'b0);
        checkOutput("oob_rd_ack", 32'(last_ack), 32'h8);
        checkOutput("oob_rd_rdata", 32'(last_rdata), 32'h0);

        order_q.delete();
        req = 4'b1111; wr = '0; addr = 8'b10_01_10_01; wdata = '0;
        repeat (15) tick();
        req = 4'b1010;
        repeat (9) tick();
        req = '0;
        tick();
        checkOutput("rr_len", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < order_q.size(); i++)
            checkOutput($sformatf("rr_order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

        req = 4'b1000; wr = 4'b1000; addr = '0; wdata = 32'h55 << 24;
        tick();
        checkOutput("midrst_gnt", 32'(gnt), 32'h8);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_gnt0", 32'(gnt), 32'h0);
        checkOutput("midrst_ack0", 32'(ack), 32'h0);
        checkOutput("midrst_busy0", 32'(busy), 32'h0);
        checkOutput("midrst_q0", 32'(q_bank), 32'h0);
        req = '0; wr = '0; wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("postrst_word0", 32'(q_bank[0 +: W]), 32'h0);

        req = 4'b1001; wr = '0; addr = '0;
        tick();
        checkOutput("postrst_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        checkOutput("postrst_ack", 32'(ack), 32'h1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one bank of D flip-flop registers (DEPTH words × WIDTH bits) between NREQ requesters.
- Round-robin arbitration with a 3-state FSM per transaction: select, access, acknowledge.
- Owns the write enable, next-state mux and read mux of the bank.
- Sits between multiple producer/consumer blocks and the storage flops.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data bits per register word.
- DEPTH, 4, number of register words (1..2^AW).
- AW, 2, address width per requester.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request, level.
- wr  in  NREQ  per-requester op: 1 = write, 0 = read.
- addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- wdata  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-hot completion pulse, registered.
- rdata  out  WIDTH  read result; valid while ack is high.
- busy  out  1  high while a transaction is in flight.
- q_bank  out  DEPTH*WIDTH  direct view of all flops; word j at [j*WIDTH +: WIDTH].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: FSM = IDLE; gnt = 0, ack = 0, rdata = 0, busy = 0, round-robin pointer ptr = 0, all bank words = 0.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit searching upward from ptr, wrapping modulo NREQ.
  - Latch the winner index, wr, addr and wdata; go to GRANT.
  - If no req bit is set, stay in IDLE.
- GRANT (exactly 1 cycle):
  - gnt[winner] = 1; busy = 1.
  - Write: bank[addr] <= wdata at the closing edge.
  - Read: rdata <= bank[addr] at the closing edge.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - ack[winner] = 1, gnt = 0, busy = 1; rdata holds its value.
  - ptr <= (winner + 1) mod NREQ.
  - Go to IDLE.
- Latency: req sampled at edge 0 → gnt high in cycle 1 → ack high in cycle 2. Peak throughput is 1 transaction per 3 cycles.
- Read data: a read returns bank contents as of GRANT, including any write completed by an earlier transaction. rdata is don't-care outside ack, but holds its last value; it is not cleared.
- Operands are latched at the IDLE→GRANT edge. Later changes to addr, wdata, wr or req do not affect the in-flight transaction. A req dropped after selection still completes and acks.
- Requester protocol: drop req in the cycle after seeing ack. A req still high in that cycle (IDLE) is a new request; it is arbitrated normally against the advanced ptr.
- Fairness: an always-requesting set of K requesters is served in strict rotation. No requester waits more than NREQ-1 transactions.
- Out-of-range address (addr >= DEPTH): write is dropped, read returns 0, and ack is still issued.
- Untouched words: bank words not addressed by a write hold their value every cycle. q_bank updates at the GRANT closing edge.
- Reset mid-transaction: the transaction is aborted immediately. No write occurs if reset asserts before the GRANT closing edge, no ack is issued, and all state returns to reset values.
- Only one of gnt or ack is ever nonzero, and each is one-hot or zero.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → gnt = 0, ack = 0, busy = 0, q_bank = 0 immediately. Deassert, idle 5 cycles → nothing changes.
- Single write then read: req[0], wr = 1, addr = 2, wdata = 8'hA5 at edge 0 → gnt = 4'b0001 in cycle 1, ack = 4'b0001 in cycle 2, q_bank word 2 = A5. Then req[1], wr = 0, addr = 2 → ack[1] in cycle 2 of that transaction with rdata = A5.
- Round-robin: req = 4'b1111 held continuously → grant order 0, 1, 2, 3, 0. Then req = 4'b1010 from ptr = 1 → order 1, 3, 1.
- Operand latching: req[2] write addr = 1, wdata = 3C; change wdata to FF and drop req in cycle 1 → word 1 = 3C, ack[2] still pulses.
- Boundary: with DEPTH = 3, AW = 2, write addr = 3, data 77 → bank unchanged, ack issued. Read addr = 3 → rdata = 0.
- Reset mid-op: req[3] write addr = 0, data 55; assert rst during GRANT before the edge → word 0 = 0, no ack. After release, ptr = 0 and req = 4'b1001 grants requester 0 first.
